// File: rtl/irq_arbiter.sv
// irq_arbiter: round-robin interrupt arbiter with per-source claim/complete gateways.
// Define IRQ_ARBITER_EDGE_EN for rising-edge triggered sources (level triggered otherwise).
module irq_arbiter #(
    parameter int N_SRC = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_SRC-1:0] i_src,
    input  logic             i_re,
    input  logic             i_we,
    input  logic [1:0]       i_addr,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata,
    output logic             o_rvalid,
    output logic             o_ext_int
);
    localparam logic [N_SRC-1:0] ONE = N_SRC'(1);
    logic [N_SRC-1:0] pend, serv, enable, trig, elig, claim_vec, cmp_vec;
    logic [4:0]       ptr, win;
    logic             claim;
    logic [31:0]      rd_mux;
    logic             unused;
`ifdef IRQ_ARBITER_EDGE_EN
    logic [N_SRC-1:0] hist;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) hist <= '0;
        else hist <= i_src;
    end
    assign trig = i_src & ~hist;
`else
    assign trig = i_src;
`endif
    assign unused = ^i_wdata;
    assign elig = pend & enable;
    // Scanning backwards lets the earliest index in round-robin order overwrite the rest.
    always_comb begin
        win = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (|(elig & (ONE << ((int'(ptr) + i) % N_SRC)))) win = 5'((int'(ptr) + i) % N_SRC);
    end
    assign claim = i_re && i_addr == 2'd2 && |elig && !(|serv);
    assign claim_vec = claim ? ONE << win : '0;
    // ID 0 wraps to a shift of 31 and IDs above N_SRC shift out, so both select no source.
    assign cmp_vec = (i_we && i_addr == 2'd2) ? ONE << (i_wdata[4:0] - 5'd1) : '0;
    assign rd_mux = i_addr == 2'd0 ? 32'(enable) :
                    i_addr == 2'd1 ? 32'(pend) :
                    claim ? 32'(win) + 32'd1 : '0;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pend      <= '0;
            serv      <= '0;
            enable    <= '0;
            ptr       <= '0;
            o_rdata   <= '0;
            o_rvalid  <= 1'b0;
            o_ext_int <= 1'b0;
        end else begin
            pend <= (pend & ~claim_vec) | (trig & ~pend & ~serv);
            serv <= (serv & ~cmp_vec) | claim_vec;
            if (i_we && i_addr == 2'd0) enable <= i_wdata[N_SRC-1:0];
            if (claim) ptr <= win == 5'(N_SRC - 1) ? '0 : win + 5'd1;
            if (i_re) o_rdata <= rd_mux;
            o_rvalid  <= i_re;
            o_ext_int <= |elig && !(|serv);
        end
    end
endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: directed scoreboard bench for irq_arbiter (N_SRC = 8).
module tb_irq_arbiter;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [7:0]  i_src = '0;
    logic        i_re = 1'b0;
    logic        i_we = 1'b0;
    logic [1:0]  i_addr = '0;
    logic [31:0] i_wdata = '0;
    logic [31:0] o_rdata;
    logic        o_rvalid;
    logic        o_ext_int;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
`ifdef IRQ_ARBITER_EDGE_EN
    localparam bit LEVEL = 1'b0;
`else
    localparam bit LEVEL = 1'b1;
`endif

    irq_arbiter #(.N_SRC(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_src(i_src), .i_re(i_re), .i_we(i_we),
        .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata), .o_rvalid(o_rvalid),
        .o_ext_int(o_ext_int)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (!i_rst && o_rvalid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rvalid_unexpected: got rdata %0h expected no response", o_rdata);
            end else chk(name_q.pop_front(), o_rdata, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string name);
        i_re = 1'b1;
        i_addr = a;
        exp_q.push_back(e);
        name_q.push_back(name);
        tick();
        i_re = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        i_we = 1'b1;
        i_addr = a;
        i_wdata = d;
        tick();
        i_we = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] s);
        i_src = s;
        tick();
        i_src = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        #2 i_rst = 1'b1;
        #1;
        chk("rst_rdata", o_rdata, 0);
        chk("rst_rvalid", 32'(o_rvalid), 0);
        chk("rst_ext_int", 32'(o_ext_int), 0);
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        // round robin over sources 1,4,6 then wrap
        wr(0, 32'hFF);
        pulse(8'h29);
        rd(2, 1, "rr_claim1"); wr(2, 1);
        rd(2, 4, "rr_claim4"); wr(2, 4);
        rd(2, 6, "rr_claim6"); wr(2, 6);
        pulse(8'h29);
        rd(1, 32'h29, "rr_pending_all");
        rd(2, 1, "rr_wrap_claim1"); wr(2, 1);
        rd(1, 32'h28, "rr_pending_rest");
        rd(2, 4, "rr_claim4b"); wr(2, 4);
        rd(2, 6, "rr_claim6b"); wr(2, 6);
        // single pulse on source 3
        pulse(8'h04);
        chk("p3_ext_int_early", 32'(o_ext_int), 0);
        rd(1, 32'h04, "p3_pending");
        chk("p3_ext_int_set", 32'(o_ext_int), 1);
        rd(2, 3, "p3_claim");
        idle(1);
        chk("p3_ext_int_clr", 32'(o_ext_int), 0);
        wr(2, 3);
        // source in service blocks further claims
        pulse(8'h04);
        rd(2, 3, "serv_claim3");
        pulse(8'h10);
        idle(1);
        chk("serv_ext_int_blk", 32'(o_ext_int), 0);
        rd(2, 0, "serv_claim_blk");
        rd(1, 32'h10, "serv_pending5");
        wr(2, 3);
        idle(1);
        chk("serv_ext_int_rel", 32'(o_ext_int), 1);
        wr(2, 7);
        rd(1, 32'h10, "serv_bogus_cmp");
        chk("serv_ext_int_keep", 32'(o_ext_int), 1);
        rd(2, 5, "serv_claim5");
        wr(2, 0);
        wr(2, 9);
        pulse(8'h02);
        idle(1);
        chk("serv_badid_ext_int", 32'(o_ext_int), 0);
        rd(2, 0, "serv_badid_claim");
        wr(2, 5);
        idle(1);
        chk("serv_cmp5_ext_int", 32'(o_ext_int), 1);
        rd(2, 2, "serv_claim2");
        wr(2, 2);
        // disabled source stays pending but unclaimable
        wr(0, 0);
        i_src = 8'h01;
        tick();
        rd(1, 32'h01, "dis_pending");
        chk("dis_ext_int", 32'(o_ext_int), 0);
        rd(2, 0, "dis_claim");
        wr(0, 32'h01);
        chk("en_ext_int_lat", 32'(o_ext_int), 0);
        idle(1);
        chk("en_ext_int", 32'(o_ext_int), 1);
        i_src = '0;
        rd(2, 1, "en_claim1");
        wr(2, 1);
        // register map corners
        wr(0, 32'hFFFF_FFFF);
        rd(0, 32'hFF, "enable_upper");
        rd(3, 0, "reserved_rd");
        wr(3, 32'h1234);
        rd(0, 32'hFF, "reserved_wr");
        wr(1, 32'hFF);
        rd(1, 0, "pending_ro");
        i_re = 1'b1;
        exp_q.push_back(32'hFF);
        name_q.push_back("rw_same_cycle");
        wr(0, 32'h0F);
        i_re = 1'b0;
        rd(0, 32'h0F, "rw_new_enable");
        wr(0, 32'hFF);
        // held source after complete
        i_src = 8'h02;
        tick();
        rd(2, 2, "hold_claim2");
        wr(2, 2);
        idle(1);
        rd(1, LEVEL ? 32'h02 : 32'h0, "hold_pending");
        i_src = '0;
        rd(2, LEVEL ? 32'h2 : 32'h0, "hold_reclaim");
        wr(2, 2);
        // asynchronous reset mid-service
        pulse(8'h01);
        rd(2, 1, "ar_claim1");
        idle(1);
        #2 i_rst = 1'b1;
        #1;
        chk("ar_rdata", o_rdata, 0);
        chk("ar_rvalid", 32'(o_rvalid), 0);
        chk("ar_ext_int", 32'(o_ext_int), 0);
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        rd(1, 0, "ar_pending");
        rd(0, 0, "ar_enable");
        rd(2, 0, "ar_claim");
        wr(0, 32'hFF);
        rd(2, 0, "ar_claim_en");
        pulse(8'h80);
        rd(2, 8, "ar_claim8");
        wr(2, 8);
        idle(2);
        chk("ar_ext_int_end", 32'(o_ext_int), 0);
        chk("rsp_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/irq_arbiter.md
IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 Parameter: N_SRC, default 8, number of external interrupt sources, legal range 1..31.
REQ-002 Port: i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: i_rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: i_src  input  N_SRC  interrupt request per source, synchronous to i_clk; bit k is source ID k+1.
REQ-005 Port: i_re  input  1  register read strobe, one cycle.
REQ-006 Port: i_we  input  1  register write strobe, one cycle.
REQ-007 Port: i_addr  input  2  register select: 0 ENABLE, 1 PENDING, 2 CLAIM/COMPLETE, 3 reserved.
REQ-008 Port: i_wdata  input  32  write data.
REQ-009 Port: o_rdata  output  32  read data, registered.
REQ-010 Port: o_rvalid  output  1  o_rdata valid, one cycle.
REQ-011 Port: o_ext_int  output  1  registered interrupt request to the CSR unit external-interrupt input.

Function
REQ-012 Per-source gateway state: IDLE, PEND, SERV; at most one source in SERV at any time.
REQ-013 IDLE->PEND when trigger condition (REQ-030/031) holds; the source's ENABLE bit does not gate this.
REQ-014 PEND->SERV only via claim of that source; SERV->IDLE only via complete naming that source.
REQ-015 Trigger while in PEND or SERV is discarded; no queueing.
REQ-016 Eligible set = PEND & ENABLE[N_SRC-1:0].
REQ-017 Winner selected round-robin: search starts at index ptr, wraps past N_SRC-1 to 0; first eligible index wins.
REQ-018 ptr resets to 0; on a claim of index k, ptr <= (k+1) mod N_SRC; unchanged otherwise.
REQ-019 Read of CLAIM (i_re, addr 2): returns winner ID (index+1) in bits [4:0], upper bits 0; winner moves to SERV in the same edge; returns 0 with no state change if no eligible source or a source already in SERV.
REQ-020 Write of CLAIM (i_we, addr 2) = complete: i_wdata[4:0] = ID; if that source is in SERV it returns to IDLE; otherwise ignored (incl. ID 0, ID > N_SRC).
REQ-021 ENABLE: read/write, bits [N_SRC-1:0] writable, upper bits read 0; clearing a bit leaves PEND state intact.
REQ-022 PENDING: read-only, bit k = source k in PEND; writes ignored.
REQ-023 Reserved address: reads return 0, writes ignored.
REQ-024 Read latency 1 cycle: o_rdata/o_rvalid valid the cycle after i_re; o_rdata holds last value when o_rvalid low.
REQ-025 i_re and i_we in the same cycle: write takes effect, read returns pre-write state.
REQ-026 o_ext_int <= (eligible set non-empty) && (no source in SERV); one-cycle latency from state change.
REQ-027 Claim and trigger of a different source same edge: both apply; a complete and re-trigger of the same source same edge: source ends in IDLE, re-trigger discarded in level mode only if still asserted next cycle re-enters PEND.
REQ-028 Claim and complete in the same cycle is impossible (REQ-025 rule applies: complete performed, claim result reflects pre-complete state).

Reset
REQ-029 Asynchronous assertion of i_rst forces: all gateways IDLE, ENABLE=0, ptr=0, o_rdata=0, o_rvalid=0, o_ext_int=0, edge-detect history=0; mid-claim/mid-service state is discarded; deassertion takes effect at the next rising edge.

Configuration
REQ-030 Macro IRQ_ARBITER_EDGE_EN defined: trigger = rising edge of i_src[k] (i_src[k]=1, previous sample 0); one registered history bit per source.
REQ-031 Macro IRQ_ARBITER_EDGE_EN undefined: trigger = i_src[k] high (level); no history registers; a source still high after complete re-enters PEND next edge.

Verification
REQ-032 ENABLE=0xFF, pulse i_src[2] -> PENDING=0x04 next cycle, o_ext_int=1 one cycle later; CLAIM read returns 3, o_ext_int=0 next cycle.
REQ-033 Sources 1,4,6 (indices 0,3,5) pending, ENABLE=0xFF, ptr=0 -> successive claim/complete loops return 1,4,6; re-trigger all, next claim returns 1 (ptr wrapped from 6).
REQ-034 Source 3 in SERV, source 5 pending -> CLAIM read returns 0, o_ext_int=0; complete with 3 -> o_ext_int=1; complete with 7 while nothing in SERV -> no change.
REQ-035 ENABLE=0x00, i_src[0] asserted -> PENDING=0x01, o_ext_int=0, claim returns 0; write ENABLE=0x01 -> o_ext_int=1 two cycles later.
REQ-036 i_src[1] held high: with IRQ_ARBITER_EDGE_EN, claim+complete -> PENDING=0 afterwards; without it -> PENDING=0x02 one cycle after complete.
REQ-037 Assert i_rst asynchronously between clock edges while a source is in SERV -> all outputs 0 immediately; after release CLAIM read returns 0 until a new trigger.
